testram_reader: RTL and testbench
=================================

// Module: testram_reader
// PURPOSE
//  Test-side reader for a synchronous-read dual-port test RAM (1-cycle read latency, no read enable).
//  On START it streams LEN words from BASE, wrapping modulo 2**AWIDTH, out of the RAM read port.
//  Output is a valid/ready stream; a 2-entry skid buffer absorbs the RAM latency under backpressure.
//  Used by the Core10100 testbench to replay frames that the bench or DUT wrote into the RAM.
// PARAMETERS
//  AWIDTH  10  RAM address width; also the width of BASE and RADDR
//  DWIDTH  8   RAM data width; also the width of RDATA and DOUT
//  LWIDTH  11  LEN width; must be at least AWIDTH+1 so a full-RAM transfer can be requested
// PORTS
//  CLK     in   1       single clock; RAM read port CLKR is driven from the same clock
//  RST     in   1       asynchronous reset, active-high
//  START   in   1       start a transfer; sampled only in IDLE
//  ABORT   in   1       cancel the transfer in progress
//  BASE    in   AWIDTH  first address; sampled with START
//  LEN     in   LWIDTH  word count; sampled with START
//  RADDR   out  AWIDTH  RAM read address (registered)
//  RDATA   in   DWIDTH  RAM read data; valid one cycle after RADDR is presented
//  DOUT    out  DWIDTH  stream data (head of the skid buffer)
//  DVALID  out  1       DOUT is valid
//  DREADY  in   1       sink accepts; a word transfers on any edge where DVALID && DREADY
//  DLAST   out  1       DOUT is the final word of the transfer
//  BUSY    out  1       transfer in progress
//  DONE    out  1       one-cycle pulse after the last word is accepted
// BEHAVIOUR
//  Reset: RADDR=0, DVALID=0, DLAST=0, BUSY=0, DONE=0, DOUT=0, buffer empty, state IDLE.
//   RST asserted mid-transfer drops everything immediately.
//  States: IDLE, READ (words still to issue), DRAIN (all reads issued; buffer not yet empty).
//  IDLE + START, LEN!=0: latch addr=BASE, remaining=LEN, BUSY=1, go to READ.
//  IDLE + START, LEN==0: no RAM read; DONE=1 for one cycle; BUSY stays 0; stay IDLE.
//  START outside IDLE is ignored. BASE and LEN are not re-sampled during a transfer.
//  Issue rule, evaluated each cycle in READ: issue when (count + inflight - pop) < 2.
//   count = buffer occupancy (0..2); inflight = read issued last cycle; pop = DVALID && DREADY.
//   On issue: RADDR presents addr; addr increments by 1 with wrap 2**AWIDTH-1 -> 0; remaining decrements; inflight=1 next cycle.
//   The issue that takes remaining to 0 tags its word last=1 and moves the state to DRAIN.
//  Push: when inflight=1, RDATA and its last tag are written to the buffer at that edge.
//   The issue rule guarantees no overflow; a simultaneous push and pop are both honoured.
//  Latency: START edge E0 -> RADDR=BASE after E0 -> RAM samples at E1 -> word pushed at E2.
//   DVALID is high from E2 with DOUT=RAM[BASE].
//  Throughput: 1 word/cycle while DREADY=1. With DREADY=0, DOUT and DLAST hold stable; no words are lost or duplicated.
//  DLAST = last tag of the buffer head; it is qualified by DVALID.
//  Completion: at the edge where the DLAST word is popped -> state IDLE, BUSY=0, DONE=1 for one cycle, DVALID=0 unless START is reused.
//   A new START is accepted on the cycle DONE is high.
//  ABORT, in READ or DRAIN: at the next edge, buffer flushed, inflight cleared, DVALID=0, BUSY=0, state IDLE, no DONE.
//   ABORT in IDLE has no effect. ABORT with START in the same cycle: ABORT wins.
//  LEN > 2**AWIDTH: addresses repeat after wrap; words are streamed in order regardless.
// TESTING
//  RAM[0..3]=A0..A3; START, BASE=0, LEN=4, DREADY=1 -> DVALID from E2, DOUT A0,A1,A2,A3 on consecutive cycles; DLAST on A3; DONE one cycle later.
//  BASE=1022, LEN=4, AWIDTH=10 -> RADDR 1022,1023,0,1; DOUT follows that order; DLAST on the RAM[1] word.
//  LEN=3 with DREADY toggling 1,0,0,1,0,1 -> exactly 3 words accepted, in order; DOUT stable while DREADY=0; buffer never exceeds 2.
//  START with LEN=0 -> DONE pulse one cycle later; RADDR unchanged; DVALID and BUSY stay 0.
//  ABORT raised after 2 of 8 words accepted -> DVALID=0 and BUSY=0 next cycle, no DONE; a new START then streams correctly from its own BASE.
//  RST pulsed mid-transfer, then START BASE=5, LEN=2 -> all outputs 0 during reset; afterwards DOUT=RAM[5],RAM[6] with DLAST on RAM[6].

Source files
------------

// File: rtl/testram_reader.sv
// testram_reader: streams LEN words from a synchronous-read test RAM,
// starting at BASE and wrapping modulo 2**AWIDTH, onto a valid/ready port.
// A 2-entry skid buffer absorbs the 1-cycle RAM read latency under backpressure.
module testram_reader #(
  parameter int unsigned AWIDTH = 10,
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned LWIDTH = 11
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              ABORT,
  input  logic [AWIDTH-1:0] BASE,
  input  logic [LWIDTH-1:0] LEN,
  output logic [AWIDTH-1:0] RADDR,
  input  logic [DWIDTH-1:0] RDATA,
  output logic [DWIDTH-1:0] DOUT,
  output logic              DVALID,
  input  logic              DREADY,
  output logic              DLAST,
  output logic              BUSY,
  output logic              DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [LWIDTH-1:0] remaining;
  logic              inflight;
  logic              inflight_last;

  // Skid buffer: entry 0 is the head and drives DOUT directly.
  logic              buf0_last;
  logic [DWIDTH-1:0] buf1_data;
  logic              buf1_last;
  logic [1:0]        count;

  logic              issue;
  logic              push;
  logic              pop;
  logic              flush;
  logic              start_ok;
  logic              done_nxt;
  logic [2:0]        occ;
  logic [2:0]        occ_limit;

  assign DVALID = (count != 2'd0);
  assign DLAST  = DVALID && buf0_last;
  assign BUSY   = (state != S_IDLE);

  // Next-state, read issue and buffer control decisions.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    flush     = 1'b0;
    start_ok  = 1'b0;
    done_nxt  = 1'b0;
    pop       = DVALID && DREADY;
    push      = inflight;
    occ       = {1'b0, count} + {2'b00, inflight};
    occ_limit = 3'd2 + {2'b00, pop};
    case (state)
      S_IDLE: begin
        // ABORT takes precedence over a coincident START.
        if (START && !ABORT) begin
          if (LEN != '0) begin
            start_ok  = 1'b1;
            state_nxt = S_READ;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      S_READ: begin
        if (ABORT) begin
          flush     = 1'b1;
          state_nxt = S_IDLE;
        end else if (occ < occ_limit) begin
          issue = 1'b1;
          if (remaining == LWIDTH'(1)) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ABORT) begin
          flush     = 1'b1;
          state_nxt = S_IDLE;
        end else if (pop && DLAST) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Address/count tracking and the in-flight read tag.
  // RADDR doubles as the next address to read: the RAM samples it at the
  // issue edge, so the register must already hold BASE right after START.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RADDR         <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      DONE          <= done_nxt;
      inflight      <= issue;
      inflight_last <= issue && (remaining == LWIDTH'(1));
      if (start_ok) begin
        RADDR     <= BASE;
        remaining <= LEN;
      end else if (issue) begin
        RADDR     <= RADDR + AWIDTH'(1);
        remaining <= remaining - LWIDTH'(1);
      end
    end
  end

  // Skid buffer: push the returning RAM word, pop on handshake, flush on abort.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT      <= '0;
      buf0_last <= 1'b0;
      buf1_data <= '0;
      buf1_last <= 1'b0;
      count     <= 2'd0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            DOUT      <= RDATA;
            buf0_last <= inflight_last;
          end else begin
            buf1_data <= RDATA;
            buf1_last <= inflight_last;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          DOUT      <= buf1_data;
          buf0_last <= buf1_last;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            DOUT      <= RDATA;
            buf0_last <= inflight_last;
          end else begin
            DOUT      <= buf1_data;
            buf0_last <= buf1_last;
            buf1_data <= RDATA;
            buf1_last <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_testram_reader.sv
// Directed bench for testram_reader with a behavioural synchronous-read RAM.
module tb_testram_reader;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 11;
  localparam int unsigned DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          ABORT;
  logic [AW-1:0] BASE;
  logic [LW-1:0] LEN;
  logic [AW-1:0] RADDR;
  logic [DW-1:0] RDATA;
  logic [DW-1:0] DOUT;
  logic          DVALID;
  logic          DREADY;
  logic          DLAST;
  logic          BUSY;
  logic          DONE;

  logic [DW-1:0] mem [DEPTH];

  int tests = 0;
  int fails = 0;

  testram_reader #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .BASE(BASE), .LEN(LEN),
    .RADDR(RADDR), .RDATA(RDATA), .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY),
    .DLAST(DLAST), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read RAM, one cycle latency.
  always @(posedge CLK) RDATA <= mem[RADDR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Start a transfer and consume it with a repeating DREADY pattern.
  task automatic stream(input int base, input int len, input logic [7:0] pat,
                        input int plen, input bit chk_timing);
    int acc = 0;
    int cyc = 0;
    logic [DW-1:0] held = '0;
    bit holding = 0;
    START = 1'b1;
    BASE = AW'(base);
    LEN = LW'(len);
    DREADY = 1'b1;
    step();
    START = 1'b0;
    check("busy_start", BUSY, 1);
    while (acc < len && cyc < 200) begin
      if (chk_timing && cyc < len) check("raddr", RADDR, (base + cyc) % DEPTH);
      if (chk_timing && cyc == 1) check("dvalid_e1", DVALID, 0);
      if (chk_timing && cyc == 2) check("dvalid_e2", DVALID, 1);
      if (holding) check("hold_dout", DOUT, held);
      DREADY = pat[cyc % plen];
      holding = 0;
      if (DVALID) begin
        if (DREADY) begin
          check("dout", DOUT, mem[(base + acc) % DEPTH]);
          check("dlast", DLAST, (acc == len - 1) ? 1 : 0);
          acc++;
        end else begin
          held = DOUT;
          holding = 1;
        end
      end
      step();
      cyc++;
    end
    check("accepted", acc, len);
    check("done", DONE, 1);
    check("busy_end", BUSY, 0);
    check("dvalid_end", DVALID, 0);
    DREADY = 1'b1;
    step();
    check("done_off", DONE, 0);
  endtask

  logic [AW-1:0] ra_saved;

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'((i * 7 + 3) & 8'hff);
    for (int i = 0; i < 4; i++) mem[i] = DW'(8'hA0 + i);
    mem[1022] = 8'hE2;
    mem[1023] = 8'hE3;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0; BASE = '0; LEN = '0; DREADY = 1'b1;
    step();
    step();
    check("rst_raddr", RADDR, 0);
    check("rst_dvalid", DVALID, 0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_dout", DOUT, 0);
    RST = 1'b0;
    step();

    // Basic 4-word transfer with full-rate sink.
    stream(0, 4, 8'hFF, 1, 1'b1);
    // Address wrap at the top of the RAM.
    stream(1022, 4, 8'hFF, 1, 1'b1);
    // Backpressure pattern 1,0,0,1,0,1.
    stream(40, 3, 8'b0010_1001, 6, 1'b0);
    stream(200, 7, 8'b0000_0110, 3, 1'b0);

    // Zero-length request.
    ra_saved = RADDR;
    START = 1'b1; BASE = 10'd300; LEN = '0;
    step();
    START = 1'b0;
    check("len0_done", DONE, 1);
    check("len0_busy", BUSY, 0);
    check("len0_dvalid", DVALID, 0);
    check("len0_raddr", RADDR, ra_saved);
    step();
    check("len0_done_off", DONE, 0);

    // Abort after two of eight words accepted.
    START = 1'b1; BASE = 10'd10; LEN = 11'd8; DREADY = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    check("abort_w0", DOUT, mem[10]);
    step();
    check("abort_w1", DOUT, mem[11]);
    step();
    ABORT = 1'b1;
    step();
    ABORT = 1'b0;
    check("abort_dvalid", DVALID, 0);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    step();
    check("abort_done2", DONE, 0);
    stream(100, 3, 8'hFF, 1, 1'b1);

    // Reset mid-transfer.
    START = 1'b1; BASE = 10'd20; LEN = 11'd6;
    step();
    START = 1'b0;
    step();
    step();
    RST = 1'b1;
    #2;
    check("mid_rst_raddr", RADDR, 0);
    check("mid_rst_dvalid", DVALID, 0);
    check("mid_rst_dlast", DLAST, 0);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_dout", DOUT, 0);
    step();
    RST = 1'b0;
    step();
    check("post_rst_dvalid", DVALID, 0);
    stream(5, 2, 8'hFF, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
